// File: rtl/axis_pkt_gen_pkg.sv
// Shared types for the AXI-Stream packet generator and its pattern predictor.
package axis_pkg;

   localparam int unsigned MODE_W = 2;

   typedef enum logic [1:0] {
      StIdle,
      StSend,
      StGap
   } state_e;

   typedef enum logic [MODE_W-1:0] {
      PAT_INC   = 2'd0,
      PAT_CONST = 2'd1,
      PAT_INV   = 2'd2,
      PAT_ROT   = 2'd3
   } mode_e;

endpackage

// File: rtl/axis_pkt_gen_if.sv
// AXI-Stream link with side-band pattern mode and one-bit packet id.
interface axis_intf #(
   parameter int unsigned DATA_WIDTH = 32
) ();

   logic                         tvalid;
   logic                         tready;
   logic [DATA_WIDTH-1:0]        tdata;
   logic                         tlast;
   logic [axis_pkg::MODE_W-1:0]  cfg;
   logic                         tid;

   modport master (
      output tvalid,
      input  tready,
      output tdata,
      output tlast,
      output cfg,
      output tid
   );

   modport slave (
      input  tvalid,
      output tready,
      input  tdata,
      input  tlast,
      input  cfg,
      input  tid
   );

endinterface

// File: rtl/axis_pkt_gen_pattern.sv
// Combinational payload pattern; shared with the sink-side checker to predict data.
module axis_pattern_gen
   import axis_pkg::*;
#(
   parameter int unsigned DATA_WIDTH = 32
) (
   input  mode_e                 mode,
   input  logic [DATA_WIDTH-1:0] seed,
   input  logic [DATA_WIDTH-1:0] glob_idx,
   output logic [DATA_WIDTH-1:0] data
);

   localparam int unsigned ShW = (DATA_WIDTH > 1) ? $clog2(DATA_WIDTH) : 1;

   logic [DATA_WIDTH-1:0] sum;
   logic [DATA_WIDTH-1:0] rot;
   logic [ShW-1:0]        sh;
   int unsigned           rsh;

   always_comb begin
      sum = seed + glob_idx;
      sh  = ShW'(glob_idx % DATA_WIDTH);
      rsh = DATA_WIDTH - 32'(sh);
      // A shift by the full width yields zero, so sh == 0 leaves seed intact.
      rot = (seed << sh) | (seed >> rsh);
   end

   always_comb begin
      data = sum;
      unique case (mode)
         PAT_INC:   data = sum;
         PAT_CONST: data = seed;
         PAT_INV:   data = ~sum;
         PAT_ROT:   data = rot;
         default:   data = sum;
      endcase
   end

endmodule

// File: rtl/axis_pkt_gen.sv
// AXI-Stream packet source: programmable packet count/length, gap, pattern and alternating tid.
module axis_pkt_gen
   import axis_pkg::*;
#(
   parameter int unsigned DATA_WIDTH = 32,
   parameter int unsigned LEN_WIDTH  = 8,
   parameter int unsigned CNT_WIDTH  = 8,
   parameter int unsigned GAP        = 2
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic                  start,
   input  logic [LEN_WIDTH-1:0]  pkt_len,
   input  logic [CNT_WIDTH-1:0]  pkt_cnt,
   input  logic [MODE_W-1:0]     mode,
   input  logic [DATA_WIDTH-1:0] seed,
   axis_intf.master              m,
   output logic                  busy,
   output logic                  done
);

   localparam int unsigned GapW = (GAP > 1) ? $clog2(GAP) : 1;
   localparam logic [GapW-1:0] GapLast = (GAP > 0) ? GapW'(GAP - 1) : '0;

   state_e                state_q, state_d;
   logic [LEN_WIDTH-1:0]  len_q, len_d;
   logic [CNT_WIDTH-1:0]  cnt_q, cnt_d;
   mode_e                 mode_q, mode_d;
   logic [DATA_WIDTH-1:0] seed_q, seed_d;
   logic [LEN_WIDTH-1:0]  beat_idx_q, beat_idx_d;
   logic [CNT_WIDTH-1:0]  pkt_idx_q, pkt_idx_d;
   logic [DATA_WIDTH-1:0] glob_idx_q, glob_idx_d;
   logic [GapW-1:0]       gap_cnt_q, gap_cnt_d;
   logic                  tid_q, tid_d;
   logic                  done_q, done_d;

   logic                  tvalid;
   logic                  last_beat;
   logic                  hs;
   logic [DATA_WIDTH-1:0] pat_data;

   assign tvalid    = (state_q == StSend);
   assign last_beat = (beat_idx_q == len_q);
   assign hs        = tvalid & m.tready;

   always_comb begin
      state_d    = state_q;
      len_d      = len_q;
      cnt_d      = cnt_q;
      mode_d     = mode_q;
      seed_d     = seed_q;
      beat_idx_d = beat_idx_q;
      pkt_idx_d  = pkt_idx_q;
      glob_idx_d = glob_idx_q;
      gap_cnt_d  = gap_cnt_q;
      tid_d      = tid_q;
      done_d     = 1'b0;

      unique case (state_q)
         StIdle: begin
            if (start) begin
               len_d      = pkt_len;
               cnt_d      = pkt_cnt;
               mode_d     = mode_e'(mode);
               seed_d     = seed;
               beat_idx_d = '0;
               pkt_idx_d  = '0;
               glob_idx_d = '0;
               gap_cnt_d  = '0;
               tid_d      = 1'b0;
               state_d    = StSend;
            end
         end
         StSend: begin
            if (hs) begin
               glob_idx_d = glob_idx_q + 1'b1;
               if (last_beat) begin
                  if (pkt_idx_q == cnt_q) begin
                     state_d = StIdle;
                     done_d  = 1'b1;
                  end else begin
                     beat_idx_d = '0;
                     pkt_idx_d  = pkt_idx_q + 1'b1;
                     tid_d      = ~tid_q;
                     gap_cnt_d  = '0;
                     // With no gap the next packet's first beat follows immediately.
                     state_d    = (GAP == 0) ? StSend : StGap;
                  end
               end else begin
                  beat_idx_d = beat_idx_q + 1'b1;
               end
            end
         end
         StGap: begin
            if (gap_cnt_q == GapLast) begin
               state_d = StSend;
            end else begin
               gap_cnt_d = gap_cnt_q + 1'b1;
            end
         end
         default: state_d = StIdle;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q    <= StIdle;
         len_q      <= '0;
         cnt_q      <= '0;
         mode_q     <= PAT_INC;
         seed_q     <= '0;
         beat_idx_q <= '0;
         pkt_idx_q  <= '0;
         glob_idx_q <= '0;
         gap_cnt_q  <= '0;
         tid_q      <= 1'b0;
         done_q     <= 1'b0;
      end else begin
         state_q    <= state_d;
         len_q      <= len_d;
         cnt_q      <= cnt_d;
         mode_q     <= mode_d;
         seed_q     <= seed_d;
         beat_idx_q <= beat_idx_d;
         pkt_idx_q  <= pkt_idx_d;
         glob_idx_q <= glob_idx_d;
         gap_cnt_q  <= gap_cnt_d;
         tid_q      <= tid_d;
         done_q     <= done_d;
      end
   end

   // Payload is a pure function of latched state, so it cannot move under backpressure.
   axis_pattern_gen #(
      .DATA_WIDTH (DATA_WIDTH)
   ) u_pattern (
      .mode     (mode_q),
      .seed     (seed_q),
      .glob_idx (glob_idx_q),
      .data     (pat_data)
   );

   assign m.tvalid = tvalid;
   assign m.tdata  = pat_data;
   assign m.tlast  = tvalid & last_beat;
   assign m.cfg    = mode_q;
   assign m.tid    = tid_q;
   assign busy     = (state_q != StIdle);
   assign done     = done_q;

endmodule
